// File: rtl/minimac2_tx_pkg.sv
// Shared definitions for the minimac2 transmit path: FSM encoding, MII
// preamble constants and the Ethernet CRC-32 parameters.
package minimac2_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA     = 3'd2,
        ST_PAD      = 3'd3,
        ST_FCS      = 3'd4,
        ST_IFG      = 3'd5,
        ST_DONE     = 3'd6
    } tx_state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

    // Index of the SFD within the 16-nibble preamble and of the last FCS nibble.
    localparam logic [7:0]  PREAMBLE_LAST = 8'd15;
    localparam logic [7:0]  FCS_LAST      = 8'd7;

endpackage

// File: rtl/minimac2_crc32_nib.sv
// Combinational CRC-32 advance by one nibble, LSB of the nibble first.
// Shared with the receive path.
module minimac2_crc32_nib
    import minimac2_tx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [3:0]  nib,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc;
        for (int i = 0; i < 4; i++) begin
            c = (c >> 1) ^ (((c[0] ^ nib[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        crc_next = c;
    end

endmodule

// File: rtl/minimac2_tx.sv
// MII transmit engine: preamble/SFD, payload read from the TX buffer RAM,
// optional zero pad, FCS and inter-frame gap, one nibble per tx_nibble_ce.
module minimac2_tx
    import minimac2_tx_pkg::*;
#(
    parameter int PAD_EN      = 1,
    parameter int MIN_FRAME   = 60,
    parameter int IFG_NIBBLES = 24
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tx_start,
    input  logic [10:0] tx_count,
    output logic        tx_done,
    output logic [10:0] tx_adr,
    input  logic [7:0]  tx_data,
    input  logic        tx_nibble_ce,
    output logic        phy_tx_en,
    output logic [3:0]  phy_tx_data,
    output logic [2:0]  state_dbg
);

    // Control: tx_start and tx_nibble_ce are single-cycle strobes with no
    // back-pressure. tx_start is taken only in IDLE with a non-zero count;
    // tx_done is high for the one cycle before the engine is IDLE again.

    localparam bit          PAD_ON        = (PAD_EN != 0);
    localparam logic [10:0] MIN_LEN       = 11'(MIN_FRAME);
    localparam logic [10:0] PAD_LAST_BYTE = 11'(MIN_FRAME - 1);
    localparam logic [7:0]  IFG_LAST      = 8'(IFG_NIBBLES - 1);

    tx_state_t   state;
    tx_state_t   state_next;

    logic [10:0] len;
    logic [10:0] byte_cnt;
    logic [7:0]  nib_cnt;
    logic        nib_hi;
    logic [3:0]  byte_hi;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] fcs_inv;

    logic        start_ok;
    logic        last_byte;
    logic        pad_needed;
    logic [3:0]  nib_out;
    logic        en_out;
    logic        crc_feed;

    assign start_ok   = tx_start && (state == ST_IDLE) && (tx_count != 11'd0);
    assign last_byte  = (byte_cnt == len - 11'd1);
    assign pad_needed = PAD_ON && (len < MIN_LEN);
    assign fcs_inv    = ~crc;
    assign state_dbg  = state;

    minimac2_crc32_nib u_crc (
        .crc      (crc),
        .nib      (nib_out),
        .crc_next (crc_next)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_next = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (tx_nibble_ce && nib_cnt == PREAMBLE_LAST) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (tx_nibble_ce && nib_hi && last_byte) begin
                    state_next = pad_needed ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                if (tx_nibble_ce && nib_hi && byte_cnt == PAD_LAST_BYTE) state_next = ST_FCS;
            end
            ST_FCS: begin
                if (tx_nibble_ce && nib_cnt == FCS_LAST) state_next = ST_IFG;
            end
            ST_IFG: begin
                if (tx_nibble_ce && nib_cnt == IFG_LAST) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The low nibble of each byte comes straight off the RAM port; only the
    // high nibble needs holding, since tx_adr has already moved on by then.
    always_comb begin
        nib_out  = 4'h0;
        en_out   = 1'b0;
        crc_feed = 1'b0;
        tx_done  = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                en_out  = 1'b1;
                nib_out = (nib_cnt == PREAMBLE_LAST) ? SFD_NIB : PREAMBLE_NIB;
            end
            ST_DATA: begin
                en_out   = 1'b1;
                crc_feed = 1'b1;
                nib_out  = nib_hi ? byte_hi : tx_data[3:0];
            end
            ST_PAD: begin
                en_out   = 1'b1;
                crc_feed = 1'b1;
            end
            ST_FCS: begin
                en_out  = 1'b1;
                nib_out = fcs_inv[{nib_cnt[2:0], 2'b00} +: 4];
            end
            ST_DONE: begin
                tx_done = 1'b1;
            end
            default: begin
                nib_out = 4'h0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            len         <= '0;
            byte_cnt    <= '0;
            nib_cnt     <= '0;
            nib_hi      <= 1'b0;
            byte_hi     <= '0;
            crc         <= CRC_INIT;
            tx_adr      <= '0;
            phy_tx_en   <= 1'b0;
            phy_tx_data <= '0;
        end else if (start_ok) begin
            len      <= tx_count;
            tx_adr   <= '0;
            byte_cnt <= '0;
            nib_cnt  <= '0;
            nib_hi   <= 1'b0;
            crc      <= CRC_INIT;
        end else if (tx_nibble_ce) begin
            phy_tx_en   <= en_out;
            phy_tx_data <= nib_out;
            if (crc_feed) crc <= crc_next;
            nib_cnt <= (state_next != state) ? 8'd0 : nib_cnt + 8'd1;
            if (state == ST_DATA || state == ST_PAD) begin
                nib_hi <= ~nib_hi;
                if (nib_hi) begin
                    byte_cnt <= byte_cnt + 11'd1;
                end else if (state == ST_DATA) begin
                    byte_hi <= tx_data[7:4];
                    tx_adr  <= tx_adr + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_minimac2_tx.sv
// Bench for minimac2_tx: one padding and one non-padding instance share the
// RAM and strobes; captured MII nibble streams are compared with a frame model.
module tb_minimac2_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [10:0] tx_count = '0;
    logic        tx_nibble_ce = 1'b0;

    logic [1:0]  en_m;
    logic [1:0]  done_m;
    logic [3:0]  d0, d1;
    logic [10:0] adr0, adr1;
    logic [7:0]  rd0, rd1;
    logic [2:0]  st0, st1;

    logic [7:0]  ram [0:2047];

    int checks = 0;
    int errors = 0;
    int gap_mode = 0;

    // capture state, index 0 = no pad, 1 = pad
    logic [3:0]  got_mem [2][0:8191];
    logic [3:0]  saved   [0:8191];
    int          saved_n;
    int          got_n [2];
    int          done_cnt [2];
    int          rises [2];
    int          ifg_cnt [2];
    int          ifg_seen [2];
    bit          ifg_on [2];
    bit          was_en [2];
    int          viol = 0;
    logic        ce_at_pos = 1'b0;

    logic [3:0]  exp_q [$];

    always #5 sys_clk = ~sys_clk;

    minimac2_tx #(.PAD_EN(0), .MIN_FRAME(60), .IFG_NIBBLES(24)) u_dut_np (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .tx_start     (tx_start),
        .tx_count     (tx_count),
        .tx_done      (done_m[0]),
        .tx_adr       (adr0),
        .tx_data      (rd0),
        .tx_nibble_ce (tx_nibble_ce),
        .phy_tx_en    (en_m[0]),
        .phy_tx_data  (d0),
        .state_dbg    (st0)
    );

    minimac2_tx #(.PAD_EN(1), .MIN_FRAME(60), .IFG_NIBBLES(24)) u_dut_pad (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .tx_start     (tx_start),
        .tx_count     (tx_count),
        .tx_done      (done_m[1]),
        .tx_adr       (adr1),
        .tx_data      (rd1),
        .tx_nibble_ce (tx_nibble_ce),
        .phy_tx_en    (en_m[1]),
        .phy_tx_data  (d1),
        .state_dbg    (st1)
    );

    always @(posedge sys_clk) begin
        rd0       <= ram[adr0];
        rd1       <= ram[adr1];
        ce_at_pos <= tx_nibble_ce;
    end

    // nibble strobe: fixed gap of 2 cycles or random 2..7
    initial begin
        int g;
        forever begin
            @(negedge sys_clk);
            tx_nibble_ce = 1'b1;
            @(negedge sys_clk);
            tx_nibble_ce = 1'b0;
            g = (gap_mode != 0) ? int'($urandom_range(2, 7)) : 2;
            repeat (g - 2) @(negedge sys_clk);
        end
    end

    // monitor: samples away from the active edge
    initial begin
        logic       prev_en [2];
        logic [3:0] prev_d [2];
        logic       rst_q;
        logic [3:0] d;
        rst_q = 1'b0;
        prev_en[0] = 1'b0; prev_en[1] = 1'b0;
        prev_d[0] = 4'h0;  prev_d[1] = 4'h0;
        forever begin
            @(negedge sys_clk);
            for (int i = 0; i < 2; i++) begin
                d = (i == 0) ? d0 : d1;
                if (sys_rst_n && rst_q && !ce_at_pos && (en_m[i] != prev_en[i] || d != prev_d[i])) viol++;
                prev_en[i] = en_m[i];
                prev_d[i]  = d;
                if (ce_at_pos && sys_rst_n) begin
                    if (en_m[i]) begin
                        if (!was_en[i]) rises[i]++;
                        if (got_n[i] < 8192) got_mem[i][got_n[i]] = d;
                        got_n[i]++;
                        ifg_on[i] = 1'b0;
                    end else begin
                        if (d != 4'h0) viol++;
                        if (was_en[i]) begin
                            ifg_on[i]  = 1'b1;
                            ifg_cnt[i] = 1;
                        end else if (ifg_on[i]) begin
                            ifg_cnt[i]++;
                        end
                    end
                    was_en[i] = en_m[i];
                end
                if (done_m[i]) begin
                    done_cnt[i]++;
                    ifg_seen[i] = ifg_cnt[i];
                    ifg_on[i]   = 1'b0;
                end
            end
            rst_q = sys_rst_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_capture();
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            got_n[i] = 0; done_cnt[i] = 0; rises[i] = 0;
            ifg_cnt[i] = 0; ifg_seen[i] = 0; ifg_on[i] = 1'b0; was_en[i] = 1'b0;
        end
    endtask

    task automatic start_frame(input int len);
        @(posedge sys_clk);
        #1;
        tx_count = 11'(len);
        tx_start = 1'b1;
        @(posedge sys_clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!(done_cnt[0] >= 1 && done_cnt[1] >= 1) && c < budget) begin
            @(posedge sys_clk);
            c++;
        end
        repeat (60) @(posedge sys_clk);
    endtask

    // Frame model: preamble, bytes (zero-padded to 60 when padding), and the
    // complement of a bit-serial reflected CRC-32 over all bytes, low nibble first.
    function automatic void build_expected(input int len, input bit pad);
        logic [31:0] crc;
        logic [7:0]  b;
        int          total;
        exp_q.delete();
        for (int k = 0; k < 15; k++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        total = (pad && len < 60) ? 60 : len;
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < total; k++) begin
            b = (k < len) ? ram[k] : 8'h00;
            exp_q.push_back(b[3:0]);
            exp_q.push_back(b[7:4]);
            for (int j = 0; j < 8; j++) begin
                crc = (crc >> 1) ^ (((crc[0] ^ b[j]) == 1'b1) ? 32'hEDB88320 : 32'h0);
            end
        end
        crc = ~crc;
        for (int j = 0; j < 8; j++) exp_q.push_back(crc[4*j +: 4]);
    endfunction

    task automatic compare_frame(input int i, input int len, input string name);
        int mism;
        int first;
        build_expected(len, i == 1);
        check($sformatf("%s[%0d] nibble_count", name, i), got_n[i], exp_q.size());
        mism = 0;
        first = -1;
        for (int k = 0; k < exp_q.size() && k < got_n[i]; k++) begin
            if (got_mem[i][k] !== exp_q[k]) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        if (mism != 0) $display("  %s[%0d] first bad nibble index %0d", name, i, first);
        check($sformatf("%s[%0d] bad_nibbles", name, i), mism, 0);
        check($sformatf("%s[%0d] tx_done_count", name, i), done_cnt[i], 1);
        check($sformatf("%s[%0d] ifg_ces", name, i), ifg_seen[i], 24);
        check($sformatf("%s[%0d] en_bursts", name, i), rises[i], 1);
    endtask

    task automatic fill_random(input int len);
        for (int k = 0; k < len; k++) ram[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_frame(input int len, input string name);
        clear_capture();
        start_frame(len);
        wait_done(40000);
        compare_frame(0, len, name);
        compare_frame(1, len, name);
    endtask

    initial begin
        logic [3:0] fcs_ref [8];
        int         mism;
        fcs_ref = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        for (int k = 0; k < 2048; k++) ram[k] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            got_n[i] = 0; done_cnt[i] = 0; rises[i] = 0;
            ifg_cnt[i] = 0; ifg_seen[i] = 0; ifg_on[i] = 1'b0; was_en[i] = 1'b0;
        end

        // reset state
        repeat (4) @(posedge sys_clk);
        #1;
        check("rst phy_tx_en", {30'd0, en_m}, 0);
        check("rst phy_tx_data", {d1, d0}, 0);
        check("rst tx_done", {30'd0, done_m}, 0);
        check("rst tx_adr", {adr1, adr0}, 0);
        sys_rst_n = 1'b1;
        repeat (5) @(posedge sys_clk);

        // 1) "123456789": known FCS on the non-padding instance
        for (int k = 0; k < 9; k++) ram[k] = 8'(8'h31 + k);
        run_frame(9, "t1");
        check("t1 np nibbles", got_n[0], 42);
        for (int k = 0; k < 8; k++) check($sformatf("t1 fcs nib%0d", k), got_mem[0][34 + k], fcs_ref[k]);

        // 2) short frame padded to 60 bytes
        fill_random(14);
        run_frame(14, "t2");
        check("t2 pad en ces", got_n[1], 144);

        // 3) maximum length, no wrap within the frame
        fill_random(2047);
        run_frame(2047, "t3");
        check("t3 adr end", adr0, 2047);

        // 4) ignored starts: zero count in IDLE, and a start mid-DATA
        gap_mode = 1;
        clear_capture();
        start_frame(0);
        repeat (80) @(posedge sys_clk);
        check("t4 zero-count done", done_cnt[0] + done_cnt[1], 0);
        check("t4 zero-count en", got_n[0] + got_n[1], 0);
        fill_random(30);
        start_frame(30);
        for (int c = 0; c < 2000 && got_n[0] < 24; c++) @(posedge sys_clk);
        start_frame(5);
        wait_done(40000);
        compare_frame(0, 30, "t4");
        compare_frame(1, 30, "t4");

        // 5) reset during DATA, then a normal 60-byte frame
        fill_random(20);
        clear_capture();
        start_frame(20);
        for (int c = 0; c < 2000 && got_n[0] < 26; c++) @(posedge sys_clk);
        check("t5 en before reset", {30'd0, en_m}, 3);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t5 en at reset", {30'd0, en_m}, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (400) @(posedge sys_clk);
        check("t5 no done after reset", done_cnt[0] + done_cnt[1], 0);
        fill_random(60);
        run_frame(60, "t5");

        // 6) strobe spacing must not change the stream
        fill_random(25);
        gap_mode = 0;
        run_frame(25, "t6fix");
        saved_n = got_n[1];
        for (int k = 0; k < saved_n && k < 8192; k++) saved[k] = got_mem[1][k];
        gap_mode = 1;
        run_frame(25, "t6rnd");
        check("t6 stream length", got_n[1], saved_n);
        mism = 0;
        for (int k = 0; k < saved_n && k < got_n[1] && k < 8192; k++) begin
            if (saved[k] !== got_mem[1][k]) mism++;
        end
        check("t6 stream equal", mism, 0);

        // boundary lengths around the pad threshold, plus random ones
        fill_random(200);
        run_frame(1, "len1");
        run_frame(59, "len59");
        run_frame(61, "len61");
        for (int n = 0; n < 3; n++) begin
            fill_random(120);
            run_frame(int'($urandom_range(2, 120)), $sformatf("rnd%0d", n));
        end

        check("outputs only change on ce", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
